// File: rtl/adder_operand_sequencer_pkg.sv
// Shared types and defaults for the adder operand sequencer.
// Optional subtract mode is enabled with the OPSEQ_SUB_EN macro.
package opseq_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    SHOW   = 2'd3
  } state_e;

endpackage

// File: rtl/adder_operand_sequencer_if.sv
// Operand/result bus between the key/switch side and the sequencer.
// op_sub exists only when OPSEQ_SUB_EN is defined.
interface adder_operand_sequencer_if #(
  parameter int unsigned WIDTH = opseq_pkg::WIDTH_DEF
);

  logic             go;
  logic [WIDTH-1:0] data_in;
  logic             cin_in;
  logic [WIDTH-1:0] sum_in;
  logic             cout_in;
`ifdef OPSEQ_SUB_EN
  logic             op_sub;
`endif
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             cin_out;
  logic [WIDTH:0]   result;
  logic [1:0]       state;
  logic             done;

  modport slave (
    input  go, data_in, cin_in, sum_in, cout_in,
`ifdef OPSEQ_SUB_EN
    input  op_sub,
`endif
    output a_out, b_out, cin_out, result, state, done
  );

  modport master (
    output go, data_in, cin_in, sum_in, cout_in,
`ifdef OPSEQ_SUB_EN
    output op_sub,
`endif
    input  a_out, b_out, cin_out, result, state, done
  );

endinterface

// File: rtl/adder_operand_sequencer_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous key level.
module edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic async_i,
  output logic pulse_c
);

  // [0],[1] synchronizer stages; [2] previous synchronized level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the level in and flag a low-to-high transition of the synced level
  always_comb begin
    sync_d  = {sync_q[1:0], async_i};
    pulse_c = sync_q[1] & ~sync_q[2];
  end

  // Synchronizer and history flops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= 3'b000;
    else         sync_q <= sync_d;
  end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Captures A then B/carry-in on successive go presses, latches the external
// adder's result and holds it for display. OPSEQ_SUB_EN adds subtract mode.
module adder_operand_sequencer
  import opseq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic                      clk,
  input logic                      resetn,
  adder_operand_sequencer_if.slave bus
);

  logic             go_p_c;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             done_q, done_d;

  edge_sync u_go_sync (
    .clk     (clk),
    .resetn  (resetn),
    .async_i (bus.go),
    .pulse_c (go_p_c)
  );

  // Next-state and capture logic; B is stored pre-inverted for subtract so
  // b_out/cin_out come straight from flops
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    done_d   = done_q;
    case (state_q)
      LOAD_A: begin
        if (go_p_c) begin
          a_d     = bus.data_in;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (go_p_c) begin
`ifdef OPSEQ_SUB_EN
          if (bus.op_sub) begin
            b_d = ~bus.data_in;
            c_d = 1'b1;
          end else begin
            b_d = bus.data_in;
            c_d = bus.cin_in;
          end
`else
          b_d = bus.data_in;
          c_d = bus.cin_in;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        result_d = {bus.cout_in, bus.sum_in};
        done_d   = 1'b1;
        state_d  = SHOW;
      end
      SHOW: begin
        if (go_p_c) begin
          a_d      = '0;
          b_d      = '0;
          c_d      = 1'b0;
          result_d = '0;
          done_d   = 1'b0;
          state_d  = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.a_out   = a_q;
  assign bus.b_out   = b_q;
  assign bus.cin_out = c_q;
  assign bus.result  = result_q;
  assign bus.state   = 2'(state_q);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Self-checking bench for adder_operand_sequencer with an external adder.
// Build with OPSEQ_SUB_EN defined to also exercise subtract mode.
module tb_adder_operand_sequencer;
  import opseq_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   vectors = 0;
  int   miscompares = 0;

  adder_operand_sequencer_if #(.WIDTH(4)) bus ();

  adder_operand_sequencer #(.WIDTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // The combinational ripple adder the stage drives
  assign {bus.cout_in, bus.sum_in} = 5'(bus.a_out) + 5'(bus.b_out) + 5'(bus.cin_out);

  // Reference: what the stage should display for operands a, b
  function automatic logic [4:0] ref_result(input logic [3:0] a, input logic [3:0] b,
                                           input logic ci, input logic sub);
    int unsigned diff;
    if (sub) begin
      diff = (int'(a) - int'(b) + 16) % 16;
      return {(a >= b) ? 1'b1 : 1'b0, 4'(diff)};
    end
    return 5'(int'(a) + int'(b) + int'(ci));
  endfunction

  task automatic set_sub(input logic s);
`ifdef OPSEQ_SUB_EN
    bus.op_sub = s;
`else
    if (s) $display("note: subtract requested without OPSEQ_SUB_EN");
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One key press: go held for `hold` cycles, then released long enough to re-arm
  task automatic press(input logic [3:0] d, input logic ci, input logic sub, input int hold);
    @(negedge clk);
    bus.data_in = d;
    bus.cin_in  = ci;
    set_sub(sub);
    bus.go      = 1'b1;
    repeat (hold) @(negedge clk);
    bus.go      = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.state, bus.a_out, bus.b_out, bus.cin_out, bus.result, bus.done} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got state=%0d a=%0d b=%0d cin=%0b res=%0d done=%0b want all 0",
               bus.state, bus.a_out, bus.b_out, bus.cin_out, bus.result, bus.done);
    end
  endtask

  task automatic test_basic_add();
    do_reset();
    press(4'd3, 1'b0, 1'b0, 3);
    press(4'd5, 1'b0, 1'b0, 3);
    vectors++;
    if (bus.result !== 5'b01000) begin
      miscompares++;
      $display("FAIL basic_add_result got %b want 01000", bus.result);
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.state !== 2'd3) begin
      miscompares++;
      $display("FAIL basic_add_show got done=%0b state=%0d want done=1 state=3", bus.done, bus.state);
    end
  endtask

  task automatic test_clear();
    press(4'd0, 1'b0, 1'b0, 3);
    vectors++;
    if (bus.result !== 5'd0 || bus.done !== 1'b0 || bus.state !== 2'd0 ||
        bus.a_out !== 4'd0 || bus.b_out !== 4'd0 || bus.cin_out !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_show got res=%0d done=%0b state=%0d a=%0d b=%0d cin=%0b want all 0",
               bus.result, bus.done, bus.state, bus.a_out, bus.b_out, bus.cin_out);
    end
  endtask

  task automatic test_carry();
    do_reset();
    press(4'd15, 1'b0, 1'b0, 3);
    press(4'd1, 1'b1, 1'b0, 3);
    vectors++;
    if (bus.result !== 5'b10001 || bus.cin_out !== 1'b1) begin
      miscompares++;
      $display("FAIL add_carry got res=%b cin=%0b want res=10001 cin=1", bus.result, bus.cin_out);
    end
  endtask

  task automatic test_single_step();
    do_reset();
    @(negedge clk);
    bus.data_in = 4'd6;
    bus.go      = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.state !== 2'd1 || bus.a_out !== 4'd6) begin
      miscompares++;
      $display("FAIL hold_first_step got state=%0d a=%0d want state=1 a=6", bus.state, bus.a_out);
    end
    bus.data_in = 4'd11;
    repeat (15) @(negedge clk);
    vectors++;
    if (bus.state !== 2'd1 || bus.a_out !== 4'd6) begin
      miscompares++;
      $display("FAIL hold_no_repeat got state=%0d a=%0d want state=1 a=6", bus.state, bus.a_out);
    end
    bus.go = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(4'd9, 1'b0, 1'b0, 3);
    vectors++;
    if (bus.state !== 2'd1 || bus.a_out !== 4'd9) begin
      miscompares++;
      $display("FAIL mid_capture got state=%0d a=%0d want state=1 a=9", bus.state, bus.a_out);
    end
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (bus.state !== 2'd0 || bus.a_out !== 4'd0 || bus.result !== 5'd0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got state=%0d a=%0d res=%0d done=%0b want all 0",
               bus.state, bus.a_out, bus.result, bus.done);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef OPSEQ_SUB_EN
  task automatic test_subtract();
    do_reset();
    press(4'd5, 1'b0, 1'b0, 3);
    press(4'd7, 1'b0, 1'b1, 3);
    vectors++;
    if (bus.b_out !== 4'b1000 || bus.cin_out !== 1'b1 || bus.result !== 5'b01110) begin
      miscompares++;
      $display("FAIL subtract got b=%b cin=%0b res=%b want b=1000 cin=1 res=01110",
               bus.b_out, bus.cin_out, bus.result);
    end
    press(4'd0, 1'b0, 1'b0, 3);
  endtask
`endif

  // Random operands through full capture/show/clear cycles
  task automatic test_random();
    logic [3:0] a, b;
    logic       ci, sub;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      a  = 4'($urandom);
      b  = 4'($urandom);
      ci = 1'($urandom);
`ifdef OPSEQ_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      press(a, 1'b0, 1'b0, int'($urandom_range(3, 8)));
      vectors++;
      if (bus.state !== 2'd1 || bus.a_out !== a) begin
        miscompares++;
        $display("FAIL rand_load_a[%0d] got state=%0d a=%0d want state=1 a=%0d", i, bus.state, bus.a_out, a);
      end
      press(b, ci, sub, int'($urandom_range(3, 8)));
      vectors++;
      if (bus.state !== 2'd3 || bus.done !== 1'b1 || bus.result !== ref_result(a, b, ci, sub)) begin
        miscompares++;
        $display("FAIL rand_result[%0d] got state=%0d done=%0b res=%b want state=3 done=1 res=%b",
                 i, bus.state, bus.done, bus.result, ref_result(a, b, ci, sub));
      end
      vectors++;
      if (bus.b_out !== (sub ? ~b : b) || bus.cin_out !== (sub ? 1'b1 : ci)) begin
        miscompares++;
        $display("FAIL rand_operands[%0d] got b=%b cin=%0b want b=%b cin=%0b",
                 i, bus.b_out, bus.cin_out, sub ? ~b : b, sub ? 1'b1 : ci);
      end
      press(4'($urandom), 1'($urandom), 1'b0, 3);
      vectors++;
      if (bus.state !== 2'd0 || bus.done !== 1'b0 || bus.result !== 5'd0 || bus.a_out !== 4'd0) begin
        miscompares++;
        $display("FAIL rand_clear[%0d] got state=%0d done=%0b res=%0d a=%0d want all 0",
                 i, bus.state, bus.done, bus.result, bus.a_out);
      end
    end
  endtask

  initial begin
    resetn      = 1'b0;
    bus.go      = 1'b0;
    bus.data_in = 4'd0;
    bus.cin_in  = 1'b0;
    set_sub(1'b0);
    test_reset();
    test_basic_add();
    test_clear();
    test_carry();
    test_single_step();
    test_reset_mid();
`ifdef OPSEQ_SUB_EN
    test_subtract();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
